sram_pdp_param: RTL and testbench

Parametrised synchronous pseudo-dual-port SRAM for the L0/L1 pipeline and readout buffers. Separate read and write ports operate in the same cycle, with:
- a registered, held read output and a read-valid strobe;
- a selectable read-during-write collision mode;
- out-of-range address detection for depths that are not a power of two;
- a hardware clear sweep after reset or on request.

It replaces fixed-size 128x64 instances wherever depth or width differ.

---
 rtl/sram_pdp_param.sv | 105 ++++++++++
 tb/tb_sram_pdp_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pdp_param.sv
// Parametrised pseudo-dual-port SRAM with a registered read port, selectable
// read-during-write behaviour, out-of-range detection and a hardware clear sweep.
module sram_pdp_param #(
  parameter int NUM_WORD     = 128,
  parameter int NUM_BIT      = 64,
  parameter int ADR_W        = $clog2(NUM_WORD),
  parameter bit WRITE_FIRST  = 1'b0,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               ClrReq,
  input  logic               WEB,
  input  logic [ADR_W-1:0]   WADR,
  input  logic [NUM_BIT-1:0] DataIn,
  input  logic               REB,
  input  logic [ADR_W-1:0]   RADR,
  output logic [NUM_BIT-1:0] DataOut,
  output logic               RdValid,
  output logic               AdrErr,
  output logic               Busy
);

  typedef enum logic {CLEAR, READY} state_t;

  // One extra bit so the range compare also works when NUM_WORD == 2**ADR_W.
  localparam logic [ADR_W:0]   DEPTH     = (ADR_W+1)'(NUM_WORD);
  localparam logic [ADR_W-1:0] LAST      = ADR_W'(NUM_WORD - 1);
  localparam state_t           RST_STATE = CLR_ON_RESET ? CLEAR : READY;

  logic [NUM_BIT-1:0] mem [NUM_WORD];

  state_t             state, state_nxt;
  logic [ADR_W-1:0]   cnt, cnt_nxt;
  logic               wr_en, rd_en, wr_ok, rd_ok, hit;
  logic               mem_we;
  logic [ADR_W-1:0]   mem_wadr;
  logic [NUM_BIT-1:0] mem_wdat, rd_data;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    mem_wadr  = WADR;
    mem_wdat  = DataIn;

    wr_en = (state == READY) && !WEB;
    rd_en = (state == READY) && !REB;
    wr_ok = {1'b0, WADR} < DEPTH;
    rd_ok = {1'b0, RADR} < DEPTH;
    hit   = wr_en && wr_ok && rd_en && rd_ok && (WADR == RADR);

    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_wadr = cnt;
        mem_wdat = '0;
        if (cnt == LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADR_W'(1);
        end
      end
      READY: begin
        mem_we = wr_en && wr_ok;
        if (ClrReq) state_nxt = CLEAR;
      end
      default: state_nxt = RST_STATE;
    endcase

    // The array must not be written while reset is held.
    mem_we = mem_we && rstb;

    if (!rd_ok)                 rd_data = '0;
    else if (WRITE_FIRST && hit) rd_data = DataIn;
    else                        rd_data = mem[RADR];
  end

  assign Busy = (state == CLEAR);

  // NOTE: the array has no reset branch; clearing is done by the sweep, not by rstb.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wadr] <= mem_wdat;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= RST_STATE;
      cnt     <= '0;
      DataOut <= '0;
      RdValid <= 1'b0;
      AdrErr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      RdValid <= rd_en;
      AdrErr  <= (wr_en && !wr_ok) || (rd_en && !rd_ok);
      if (rd_en) DataOut <= rd_data;
    end
  end

endmodule

// File: tb/tb_sram_pdp_param.sv
// Directed bench for sram_pdp_param: a 128-word read-first instance and a
// 384-word write-first instance exercised from a vector table plus sweep sequences.
module tb_sram_pdp_param;

  logic        clk = 1'b0;
  logic        rstb;
  logic        clr_a, clr_b, web_a, web_b, reb_a, reb_b;
  logic [8:0]  wadr, radr;
  logic [63:0] din;
  logic [63:0] dout_a, dout_b;
  logic        rv_a, rv_b, err_a, err_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_pdp_param #(.NUM_WORD(128), .NUM_BIT(64), .WRITE_FIRST(1'b0), .CLR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rstb(rstb), .ClrReq(clr_a), .WEB(web_a), .WADR(wadr[6:0]), .DataIn(din),
    .REB(reb_a), .RADR(radr[6:0]), .DataOut(dout_a), .RdValid(rv_a), .AdrErr(err_a), .Busy(busy_a)
  );

  sram_pdp_param #(.NUM_WORD(384), .NUM_BIT(64), .WRITE_FIRST(1'b1), .CLR_ON_RESET(1'b1)) u_b (
    .clk(clk), .rstb(rstb), .ClrReq(clr_b), .WEB(web_b), .WADR(wadr), .DataIn(din),
    .REB(reb_b), .RADR(radr), .DataOut(dout_b), .RdValid(rv_b), .AdrErr(err_b), .Busy(busy_b)
  );

  typedef struct {
    bit          sel;   // 0 = u_a, 1 = u_b
    bit          we;
    bit          re;
    logic [8:0]  wa;
    logic [8:0]  ra;
    logic [63:0] d;
    bit          rv;
    logic [63:0] dout;
    bit          err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] P1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] P2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] PA = 64'hAAAA_5555_0F0F_F0F0;
  localparam logic [63:0] P5 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PX = 64'h7777_0000_BEEF_0007;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr_a = 1'b0; clr_b = 1'b0;
    web_a = 1'b1; web_b = 1'b1;
    reb_a = 1'b1; reb_b = 1'b1;
  endtask

  task automatic add_vec(input bit sel, input bit we, input bit re, input logic [8:0] wa,
                         input logic [8:0] ra, input logic [63:0] d, input bit rv,
                         input logic [63:0] dout, input bit err, input string name);
    vecs.push_back('{sel, we, re, wa, ra, d, rv, dout, err, name});
  endtask

  // Counts, over a fixed window, the edges at which each Busy was high.
  task automatic sweep_count(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      step();
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'(i) ^ 32'h5A5A_5A5A};
  endfunction

  initial begin
    int na, nb, n;

    // sel we re  wa     ra     data  rv dout err
    add_vec(0, 0, 1, 9'd0,   9'd0,   '0, 1, '0, 0, "a rd0");
    add_vec(0, 0, 1, 9'd0,   9'd64,  '0, 1, '0, 0, "a rd64");
    add_vec(0, 0, 1, 9'd0,   9'd127, '0, 1, '0, 0, "a rd127");
    add_vec(0, 1, 0, 9'd5,   9'd0,   D1, 0, '0, 0, "a wr5");
    add_vec(0, 0, 1, 9'd0,   9'd5,   '0, 1, D1, 0, "a rd5");
    add_vec(0, 0, 0, 9'd0,   9'd0,   '0, 0, D1, 0, "a hold1");
    add_vec(0, 0, 0, 9'd0,   9'd0,   '0, 0, D1, 0, "a hold2");
    add_vec(0, 0, 0, 9'd0,   9'd0,   '0, 0, D1, 0, "a hold3");
    add_vec(0, 1, 0, 9'd9,   9'd0,   P1, 0, D1, 0, "a wr9");
    add_vec(0, 1, 1, 9'd9,   9'd9,   P2, 1, P1, 0, "a coll9");
    add_vec(0, 0, 1, 9'd0,   9'd9,   '0, 1, P2, 0, "a rd9");
    add_vec(1, 1, 0, 9'd9,   9'd0,   P1, 0, '0, 0, "b wr9");
    add_vec(1, 1, 1, 9'd9,   9'd9,   P2, 1, P2, 0, "b coll9");
    add_vec(1, 0, 1, 9'd0,   9'd9,   '0, 1, P2, 0, "b rd9");
    add_vec(1, 1, 0, 9'd383, 9'd0,   PA, 0, P2, 0, "b wr383");
    add_vec(1, 0, 1, 9'd0,   9'd383, '0, 1, PA, 0, "b rd383");
    add_vec(1, 1, 0, 9'd400, 9'd0,   P5, 0, PA, 1, "b wr400");
    add_vec(1, 0, 0, 9'd0,   9'd0,   '0, 0, PA, 0, "b err1shot");
    add_vec(1, 0, 1, 9'd0,   9'd400, '0, 1, '0, 1, "b rd400");
    add_vec(1, 1, 1, 9'd400, 9'd511, P5, 1, '0, 1, "b both oor");
    add_vec(1, 0, 0, 9'd0,   9'd0,   '0, 0, '0, 0, "b err2shot");
    add_vec(1, 0, 1, 9'd0,   9'd16,  '0, 1, '0, 0, "b rd16");
    add_vec(1, 0, 1, 9'd0,   9'd144, '0, 1, '0, 0, "b rd144");
    add_vec(1, 0, 1, 9'd0,   9'd0,   '0, 1, '0, 0, "b rd0");
    add_vec(1, 0, 1, 9'd0,   9'd383, '0, 1, PA, 0, "b rd383 kept");
    add_vec(1, 0, 1, 9'd0,   9'd9,   '0, 1, P2, 0, "b rd9 kept");
    add_vec(1, 1, 1, 9'd383, 9'd382, P1, 1, '0, 0, "b wr383 rd382");
    add_vec(1, 0, 1, 9'd0,   9'd383, '0, 1, P1, 0, "b rd383 new");

    // Reset state.
    idle();
    rstb = 1'b0;
    wadr = '0; radr = '0; din = '0;
    repeat (3) step();
    check("rst dout_a", dout_a, '0);
    check("rst rv_a", rv_a, 0);
    check("rst err_a", err_a, 0);
    check("rst busy_a", busy_a, 1);
    check("rst dout_b", dout_b, '0);
    check("rst busy_b", busy_b, 1);

    // Power-on sweep.
    rstb = 1'b1;
    sweep_count(na, nb);
    check("por sweep len a", 64'(na), 64'd128);
    check("por sweep len b", 64'(nb), 64'd384);
    check("por busy_a low", busy_a, 0);

    // Table-driven vectors.
    foreach (vecs[k]) begin
      idle();
      if (!vecs[k].sel) begin
        web_a = !vecs[k].we;
        reb_a = !vecs[k].re;
      end else begin
        web_b = !vecs[k].we;
        reb_b = !vecs[k].re;
      end
      wadr = vecs[k].wa;
      radr = vecs[k].ra;
      din  = vecs[k].d;
      step();
      if (!vecs[k].sel) begin
        check({vecs[k].name, " rv"},   rv_a,   vecs[k].rv);
        check({vecs[k].name, " dout"}, dout_a, vecs[k].dout);
        check({vecs[k].name, " err"},  err_a,  vecs[k].err);
      end else begin
        check({vecs[k].name, " rv"},   rv_b,   vecs[k].rv);
        check({vecs[k].name, " dout"}, dout_b, vecs[k].dout);
        check({vecs[k].name, " err"},  err_b,  vecs[k].err);
      end
    end
    idle();

    // ClrReq mid-traffic on the 128-word instance.
    for (int i = 0; i < 128; i++) begin
      web_a = 1'b0; wadr = 9'(i); din = pat(i);
      step();
    end
    web_a = 1'b1;
    reb_a = 1'b0; radr = 9'd3; clr_a = 1'b1;
    step();
    idle();
    check("clr edge rd rv", rv_a, 1);
    check("clr edge rd dout", dout_a, pat(3));
    check("clr busy set", busy_a, 1);
    n = 0;
    for (int i = 0; i < 300 && busy_a; i++) begin
      if (i == 100) begin
        web_a = 1'b0; wadr = 9'd3; din = '1;
        reb_a = 1'b0; radr = 9'd3;
      end
      n++;
      step();
      if (i == 100) begin
        idle();
        check("busy rd rv", rv_a, 0);
        check("busy dout hold", dout_a, pat(3));
      end
    end
    check("clr sweep len", 64'(n), 64'd128);
    for (int i = 0; i < 128; i++) begin
      reb_a = 1'b0; radr = 9'(i);
      step();
      check($sformatf("cleared rv %0d", i), rv_a, 1);
      check($sformatf("cleared word %0d", i), dout_a, '0);
    end
    idle();

    // Reset mid-sweep.
    web_a = 1'b0; wadr = 9'd7; din = PX;
    step();
    idle();
    reb_a = 1'b0; radr = 9'd7;
    step();
    idle();
    check("pre rst rd7", dout_a, PX);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    repeat (50) step();
    check("mid sweep busy", busy_a, 1);
    rstb = 1'b0;
    #1;
    check("mid rst dout", dout_a, '0);
    check("mid rst rv", rv_a, 0);
    check("mid rst err", err_a, 0);
    reb_a = 1'b0; radr = 9'd7; web_a = 1'b0; wadr = 9'd7; din = P5;
    repeat (2) step();
    check("mid rst dout held", dout_a, '0);
    check("mid rst rv held", rv_a, 0);
    check("mid rst busy", busy_a, 1);
    idle();
    rstb = 1'b1;
    sweep_count(na, nb);
    check("restart sweep len a", 64'(na), 64'd128);
    check("restart sweep len b", 64'(nb), 64'd384);
    reb_a = 1'b0; radr = 9'd7;
    step();
    check("post rst rd7 rv", rv_a, 1);
    check("post rst rd7", dout_a, '0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
